// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants, ID width helper and read-pipeline entry type for ram_port_arbiter
package ram_arb_pkg;
  localparam int LOCK_MAX = 16;
  localparam int ID_MAX_W = 3;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } rd_ent_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin select; search starts at ptr+1 and wraps; ports req/ptr in, one-hot gnt and gnt index idx out
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // Scan farthest-first so the nearest asserted request after ptr is the last to overwrite.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of RAM port b among N_REQ requesters with tagged read return
//   clk/res                            clock, synchronous active-high reset
//   req/req_we/req_addr/req_wdata      per-requester access (flattened buses)
//   ack                                one-hot combinational grant
//   rvalid/rdata                       one-hot read-data valid and shared read data
//   ram_addr/ram_ren/ram_wen/ram_wdata registered drive of RAM port b; ram_rdata from RAM
//   RAM_PORT_ARBITER_LOCK_EN           adds req_lock: locked owner keeps the port for up to LOCK_MAX grants
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
`ifdef RAM_PORT_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]         req_lock,
`endif
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_ren,
  output logic                     ram_wen,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);
  localparam int IW = id_w(N_REQ);
  logic [N_REQ-1:0]  w_rr_gnt, w_gnt;
  logic [IW-1:0]     w_rr_idx, w_idx;
  logic              w_any, w_rd;
  logic [IW-1:0]     r_ptr;
  logic              r_ren, r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [N_REQ-1:0]  r_rvalid;
  // Entry 0 is aligned with ram_ren; entry RD_LAT lines up with valid ram_rdata.
  rd_ent_t           r_pipe [RD_LAT+1];
  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_rr_gnt),
    .idx (w_rr_idx)
  );
`ifdef RAM_PORT_ARBITER_LOCK_EN
  logic       r_lock;
  logic [3:0] r_lock_cnt;
  logic       w_hold;
  // The pointer always names the last winner, so a held lock re-grants r_ptr.
  // Once released, plain round-robin from the owner visits everyone else first.
  assign w_hold = r_lock && req[r_ptr];
  assign w_gnt  = res ? '0 : w_hold ? (N_REQ'(1) << r_ptr) : w_rr_gnt;
  assign w_idx  = w_hold ? r_ptr : w_rr_idx;
  always_ff @(posedge clk) begin
    if (res) begin
      r_lock     <= 1'b0;
      r_lock_cnt <= '0;
    end else if (w_any) begin
      r_lock     <= req_lock[w_idx] && (r_lock_cnt != 4'(LOCK_MAX - 1));
      r_lock_cnt <= req_lock[w_idx] ? r_lock_cnt + 4'd1 : 4'd0;
    end
  end
`else
  assign w_gnt = res ? '0 : w_rr_gnt;
  assign w_idx = w_rr_idx;
`endif
  assign w_any = |w_gnt;
  assign w_rd  = w_any && !req_we[w_idx];
  always_ff @(posedge clk) begin
    if (res) begin
      r_ptr    <= IW'(N_REQ - 1);
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      for (int k = 0; k <= RD_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_ren <= w_rd;
      r_wen <= w_any && req_we[w_idx];
      if (w_any) begin
        r_ptr   <= w_idx;
        r_addr  <= req_addr[w_idx*ADDR_W +: ADDR_W];
        r_wdata <= req_wdata[w_idx*DATA_W +: DATA_W];
      end
      r_pipe[0] <= '{valid: w_rd, id: ID_MAX_W'(w_idx)};
      for (int k = 1; k <= RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      r_rvalid <= r_pipe[RD_LAT].valid ? (N_REQ'(1) << r_pipe[RD_LAT].id) : '0;
      if (r_pipe[RD_LAT].valid) r_rdata <= ram_rdata;
    end
  end
  assign ack       = w_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign ram_addr  = r_addr;
  assign ram_ren   = r_ren;
  assign ram_wen   = r_wen;
  assign ram_wdata = r_wdata;
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the hardware-side port of a dual-port register-file RAM (ram_2rw_1c port b) among N_REQ hardware requesters.
- Round-robin arbitration, one access per cycle; registered drive of the RAM port.
- Returns read data to the owning requester after the fixed RAM read latency, tagged by a requester-ID pipeline.
- Sits between RAM-backed register blocks and the hardware engines that fill or drain those RAMs.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 7, RAM address width
- DATA_W, 32, RAM data width
- RD_LAT, 1, RAM read latency in cycles from registered ren to valid rdata (1 = PIPELINED 0, 2 = PIPELINED 1)

Ports:
- clk  in  1  clock
- res  in  1  synchronous reset, active-high
- req  in  N_REQ  access request per requester, held until ack
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  flattened address, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  flattened write data
- ack  out  N_REQ  one-hot combinational grant; request consumed in this cycle
- rvalid  out  N_REQ  one-hot read-data valid, registered
- rdata  out  DATA_W  read data, shared by all requesters, qualified by rvalid
- ram_addr  out  ADDR_W  to RAM addr_b
- ram_ren  out  1  to RAM ren_b
- ram_wen  out  1  to RAM wen_b
- ram_wdata  out  DATA_W  to RAM wdata_b
- ram_rdata  in  DATA_W  from RAM rdata_b

Behaviour:
- Reset values: ram_ren=0, ram_wen=0, ram_addr=0, ram_wdata=0, rvalid=0, rdata=0, ack=0, rr pointer=N_REQ-1, ID pipeline cleared.
- Arbitration is combinational from req and the pointer.
  - Search order starts at pointer+1 and wraps modulo N_REQ.
  - The first asserted req wins; ack is one-hot, or zero when req==0.
  - On grant, the pointer loads the winner index at the next clock. With no grant, the pointer holds.
- Cycle T+1 after grant at T:
  - ram_addr and ram_wdata are taken from the winner.
  - ram_wen = we, ram_ren = !we.
  - With no grant, ram_ren=ram_wen=0; addr and wdata hold their last value.
- Reads:
  - A valid bit plus winner ID enter a depth-RD_LAT shift pipeline alongside ram_ren.
  - At T+1+RD_LAT, ram_rdata is registered into rdata, and rvalid[ID] is pulsed at T+2+RD_LAT.
  - Total read latency, ack to rvalid: RD_LAT+2 cycles.
  - Back-to-back reads from any mix of requesters produce rvalid in grant order, one per cycle.
- Writes: there is no response; ack is the completion.
- Requester rules:
  - req may drop before ack; this is legal and grants nothing.
  - A requester must hold addr, we and wdata stable while req is high and not acked.
- Fairness: with all req high, grants cycle 0,1,..,N_REQ-1,0; no requester waits more than N_REQ-1 grants.
- Reset mid-operation: in-flight reads are squashed (no rvalid). The pointer returns to N_REQ-1, so requester 0 has first priority.
- Same-address hazard between the software port a and port b is not resolved here; it is the owning register block's concern.

Optional Feature:
- Macro RAM_PORT_ARBITER_LOCK_EN adds an input req_lock (N_REQ).
- With the macro defined:
  - If the current owner is granted with req_lock set, it keeps priority on following cycles while it holds req, without losing its grant to others.
  - A 4-bit lock counter forces release after 16 consecutive locked grants. The next arbitration then skips the owner for one cycle if any other req is high.
  - The counter clears on any unlocked grant or on reset.
- Without the macro: the port and counter are absent, and arbitration is pure round-robin.

Decomposition:
- Package ram_arb_pkg:
  - localparam LOCK_MAX=16
  - ID width function clog2(N_REQ)
  - typedef for the read-pipeline entry {valid, id}
- Sub-module rr_arbiter: combinational round-robin priority select with inputs req and pointer, and outputs one-hot grant and grant index.
- The top level holds the registered RAM drive, the ID pipeline and the optional lock logic.

Test Plan:
- Reset, then a single read by requester 2 at addr 7'h05 with the RAM preloaded to 32'hCAFE0005 → ack[2] in the same cycle; ram_ren=1 and ram_addr=5 at +1; rvalid=4'b0100 and rdata=32'hCAFE0005 at +RD_LAT+2.
- All four req held high for 8 cycles, mixing reads and writes → ack sequence 0,1,2,3,0,1,2,3; writes land at their addresses; each read returns the matching data to the correct rvalid bit in grant order.
- Write 32'h12345678 to addr 3 by req 1, then a read of addr 3 by req 0 on the next cycle → rvalid[0] with 32'h12345678.
- Reads in flight for reqs 0 and 1, then res asserted for 1 cycle → no rvalid after reset; the next all-high request grants req 0 first.
- Lock-enabled build: req 3 holds req_lock and req high with req 0 also high → 16 consecutive acks to 3, then ack to 0, then 3 again.
- req 2 drops before ack while req 1 wins → no RAM access for req 2; ram_wen and ram_ren stay 0 on idle cycles.
